pe_cmd_sched: RTL and testbench

PE_CMD_SCHED -- requirements
Module: pe_cmd_sched

---
 rtl/pe_sched_pkg.sv | 28 ++
 rtl/pe_cmd_sched_if.sv | 37 +++
 rtl/pe_sched_fifo.sv | 61 ++++++
 rtl/pe_cmd_sched.sv | 178 +++++++++++++++++
 tb/tb_pe_cmd_sched.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_sched_pkg.sv
// pe_sched_pkg -- shared types and constants for the PE command scheduler.
//   OP_MAC / OP_ACT / OP_NORM : legal PE opcodes (instr[31:28])
//   state_e                   : scheduler FSM states
//   fifo_entry_t              : queued command {requester id, instruction}
//   is_legal_op()             : opcode legality check used by the FSM
package pe_sched_pkg;

  localparam logic [3:0] OP_MAC  = 4'h1;
  localparam logic [3:0] OP_ACT  = 4'h2;
  localparam logic [3:0] OP_NORM = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] instr;
  } fifo_entry_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_MAC) || (op == OP_ACT) || (op == OP_NORM);
  endfunction

endpackage

// File: rtl/pe_cmd_sched_if.sv
// pe_cmd_sched_if -- requester and PE-core signals of the command scheduler.
//   req_valid_i / req_ready_o / req_instr_i : per-requester command handshake
//   pe_valid_o / pe_ready_i / pe_instr_o    : command towards the PE core
//   pe_done_i                               : PE result-valid pulse
//   done_valid_o / done_id_o / done_err_o   : completion pulse
//   busy_o / err_timeout_o                  : status
// slave modport is the scheduler side, master the environment side.
interface pe_cmd_sched_if #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [32*NUM_REQ-1:0] req_instr_i;
  logic                  pe_valid_o;
  logic                  pe_ready_i;
  logic [31:0]           pe_instr_o;
  logic                  pe_done_i;
  logic                  done_valid_o;
  logic [1:0]            done_id_o;
  logic                  done_err_o;
  logic                  busy_o;
  logic                  err_timeout_o;

  modport slave (
    input  req_valid_i, req_instr_i, pe_ready_i, pe_done_i,
    output req_ready_o, pe_valid_o, pe_instr_o, done_valid_o,
           done_id_o, done_err_o, busy_o, err_timeout_o
  );

  modport master (
    output req_valid_i, req_instr_i, pe_ready_i, pe_done_i,
    input  req_ready_o, pe_valid_o, pe_instr_o, done_valid_o,
           done_id_o, done_err_o, busy_o, err_timeout_o
  );

endinterface

// File: rtl/pe_sched_fifo.sv
// pe_sched_fifo -- synchronous command FIFO with count-based full/empty.
//   clk, rst_n    : clock, asynchronous active-low reset
//   push, wdata   : write request (ignored when full)
//   pop, rdata    : read request (ignored when empty); rdata shows the head
//   full, empty   : status derived from the registered count
module pe_sched_fifo
  import pe_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t wdata,
  input  logic        pop,
  output fifo_entry_t rdata,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fifo_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // Head is visible combinationally so the FSM can decode it in the pop cycle.
  assign rdata   = mem[rd_ptr_reg];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage carries no reset: queued data is meaningless once the count is 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pe_cmd_sched.sv
// pe_cmd_sched -- round-robin command scheduler in front of a PE core.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pe_cmd_sched_if.slave (requesters, PE core, completion, status)
// Parameters: NUM_REQ (2..4), FIFO_DEPTH (power of two), TIMEOUT (1..255).
// Granted commands are queued, then issued one at a time to the PE; each
// produces exactly one completion pulse, in acceptance order.
module pe_cmd_sched
  import pe_sched_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  pe_cmd_sched_if.slave    bus
);

  logic [31:0] req_instr [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic        push, pop, fifo_full, fifo_empty;
  fifo_entry_t push_entry, head;
  logic [1:0]  rr_reg, rr_next;

  state_e      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [1:0]  cur_id_reg, cur_id_next;
  logic        cur_err_reg, cur_err_next;
  logic [31:0] pe_instr_reg, pe_instr_next;
  logic        timeout_hit;
  logic        pe_valid_reg, pe_valid_next;
  logic        done_valid_reg, done_valid_next;
  logic [1:0]  done_id_reg, done_id_next;
  logic        done_err_reg, done_err_next;
  logic        err_timeout_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_instr[gi] = bus.req_instr_i[32*gi +: 32];
    end
  endgenerate

  function automatic int rot_idx(input logic [1:0] base, input int off);
    return (int'(base) + off) % NUM_REQ;
  endfunction

  // Round-robin pick: first valid requester at or after rr_reg. The registered
  // full flag blocks grants even when the FSM pops in the same cycle.
  always_comb begin
    grant      = '0;
    push       = 1'b0;
    push_entry = '0;
    rr_next    = rr_reg;
    if (!fifo_full) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!push && bus.req_valid_i[rot_idx(rr_reg, i)]) begin
          grant[rot_idx(rr_reg, i)] = 1'b1;
          push             = 1'b1;
          push_entry.id    = 2'(rot_idx(rr_reg, i));
          push_entry.instr = req_instr[rot_idx(rr_reg, i)];
          rr_next          = 2'((rot_idx(rr_reg, i) + 1) % NUM_REQ);
        end
      end
    end
  end

  // Grant is combinational; hold it low while reset is asserted.
  assign bus.req_ready_o = rst_n ? grant : '0;

  pe_sched_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register together with datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_reg          <= '0;
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      cur_id_reg      <= '0;
      cur_err_reg     <= 1'b0;
      pe_instr_reg    <= '0;
      pe_valid_reg    <= 1'b0;
      done_valid_reg  <= 1'b0;
      done_id_reg     <= '0;
      done_err_reg    <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      if (push) rr_reg <= rr_next;
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      cur_id_reg      <= cur_id_next;
      cur_err_reg     <= cur_err_next;
      pe_instr_reg    <= pe_instr_next;
      pe_valid_reg    <= pe_valid_next;
      done_valid_reg  <= done_valid_next;
      done_id_reg     <= done_id_next;
      done_err_reg    <= done_err_next;
      err_timeout_reg <= err_timeout_reg | timeout_hit;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cur_id_next   = cur_id_reg;
    cur_err_next  = cur_err_reg;
    pe_instr_next = pe_instr_reg;
    pop           = 1'b0;
    timeout_hit   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          cur_id_next = head.id;
          if (is_legal_op(head.instr[31:28])) begin
            cur_err_next  = 1'b0;
            pe_instr_next = head.instr;
            state_next    = ST_ISSUE;
          end else begin
            // Illegal opcode never reaches the PE; complete with error.
            cur_err_next = 1'b1;
            state_next   = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        if (pe_valid_reg && bus.pe_ready_i) begin
          cnt_next   = '0;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.pe_done_i) begin
          cur_err_next = 1'b0;
          state_next   = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          // cnt_reg counts WAIT cycles already elapsed without a result.
          if (cnt_reg == 8'(TIMEOUT - 1)) begin
            timeout_hit  = 1'b1;
            cur_err_next = 1'b1;
            state_next   = ST_RESP;
          end
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. pe_valid rises the
  // cycle after ISSUE is entered and drops right after the handshake.
  always_comb begin
    pe_valid_next   = (state_reg == ST_ISSUE) && !(pe_valid_reg && bus.pe_ready_i);
    done_valid_next = (state_reg == ST_RESP);
    done_id_next    = (state_reg == ST_RESP) ? cur_id_reg : 2'd0;
    done_err_next   = (state_reg == ST_RESP) ? cur_err_reg : 1'b0;
  end

  assign bus.pe_valid_o    = pe_valid_reg;
  assign bus.pe_instr_o    = pe_instr_reg;
  assign bus.done_valid_o  = done_valid_reg;
  assign bus.done_id_o     = done_id_reg;
  assign bus.done_err_o    = done_err_reg;
  assign bus.err_timeout_o = err_timeout_reg;
  assign bus.busy_o        = !fifo_empty || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pe_cmd_sched.sv
// tb_pe_cmd_sched -- scoreboard bench for pe_cmd_sched (NUM_REQ=2,
// FIFO_DEPTH=4, TIMEOUT=8). Expected completions are queued at acceptance
// and compared when done_valid_o pulses.
module tb_pe_cmd_sched;
  import pe_sched_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_cmd_sched_if #(.NUM_REQ(NR)) bus ();

  pe_cmd_sched #(.NUM_REQ(NR), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]  id;
    logic        err;
    logic [31:0] instr;
  } exp_t;

  typedef logic [31:0] q_t[$];

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  exp_t sb[$];
  logic [31:0] iss_q[$];
  q_t src_q [NR];
  int grant_log[$];
  logic [NR-1:0] acc_flag = '0;
  int n_acc = 0, n_done = 0, n_hs = 0;
  int last_acc_cyc = 0, last_hs_cyc = 0, last_done_cyc = 0, last_pev_cyc = 0;
  int done_delay = 3;
  logic pe_kick = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  // Monitor / scoreboard on the falling edge.
  initial begin : monitor
    int model_rr;
    logic pev_prev;
    model_rr = 0;
    pev_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        iss_q.delete();
        model_rr = 0;
        acc_flag = '0;
        pev_prev = 1'b0;
      end else begin
        acc_flag = bus.req_valid_i & bus.req_ready_o;
        if (acc_flag != '0) begin
          int act_k, exp_k;
          logic [31:0] ins;
          logic legal;
          exp_t e;
          act_k = 0;
          exp_k = -1;
          for (int k = NR - 1; k >= 0; k--) if (acc_flag[k]) act_k = k;
          for (int i = 0; i < NR; i++) begin
            if (exp_k < 0 && bus.req_valid_i[(model_rr + i) % NR]) exp_k = (model_rr + i) % NR;
          end
          chk("grant_onehot", $countones(acc_flag), 1);
          chk("rr_grant", act_k, exp_k);
          ins = bus.req_instr_i[32*act_k +: 32];
          legal = (ins[31:28] == OP_MAC) || (ins[31:28] == OP_ACT) || (ins[31:28] == OP_NORM);
          e.id = 2'(act_k);
          e.err = !legal || (done_delay == 0);
          e.instr = ins;
          sb.push_back(e);
          if (legal) iss_q.push_back(ins);
          model_rr = (act_k + 1) % NR;
          n_acc++;
          last_acc_cyc = cyc;
          grant_log.push_back(act_k);
          $display("accept req%0d instr=%08h", act_k, ins);
        end
        if (bus.pe_valid_o && !pev_prev) last_pev_cyc = cyc;
        pev_prev = bus.pe_valid_o;
        if (bus.pe_valid_o && bus.pe_ready_i) begin
          n_hs++;
          last_hs_cyc = cyc;
          if (iss_q.size() == 0) chk("unexp_issue", 1, 0);
          else chk("pe_instr", bus.pe_instr_o, iss_q.pop_front());
        end
        if (bus.done_valid_o) begin
          n_done++;
          last_done_cyc = cyc;
          if (sb.size() == 0) begin
            chk("unexp_done", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_id", 32'(bus.done_id_o), 32'(e.id));
            chk("done_err", 32'(bus.done_err_o), 32'(e.err));
            $display("done id=%0d err=%0d instr=%08h", bus.done_id_o, bus.done_err_o, e.instr);
          end
        end
      end
    end
  end

  // PE core model: pulses pe_done_i done_delay cycles after a handshake (0 = never).
  initial begin : pe_model
    int done_cnt;
    done_cnt = 0;
    bus.pe_done_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.pe_done_i = pe_kick;
      if (!rst_n) begin
        done_cnt = 0;
      end else begin
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) bus.pe_done_i = 1'b1;
        end
        if (bus.pe_valid_o && bus.pe_ready_i) done_cnt = done_delay;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (acc_flag[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
      bus.req_valid_i[k] = (src_q[k].size() > 0);
      bus.req_instr_i[32*k +: 32] = (src_q[k].size() > 0) ? src_q[k][0] : 32'h0;
    end
  endtask

  function automatic bit all_idle();
    bit r;
    r = (sb.size() == 0) && !bus.busy_o;
    for (int k = 0; k < NR; k++) if (src_q[k].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic run_idle(input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!all_idle() && n < max);
    if (!all_idle()) chk("idle_bound", 0, 1);
  endtask

  initial begin : main
    int n0, h0, d0;
    bus.req_valid_i = '0;
    bus.req_instr_i = '0;
    bus.pe_ready_i  = 1'b0;
    // Reset state, with a requester valid to prove the grant stays low.
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid_i = 2'b11;
    bus.req_instr_i = {32'h2000_0000, 32'h1000_0000};
    #1;
    chk("rst_req_ready", 32'(bus.req_ready_o), 0);
    chk("rst_pe_valid", 32'(bus.pe_valid_o), 0);
    chk("rst_pe_instr", bus.pe_instr_o, 0);
    chk("rst_done_valid", 32'(bus.done_valid_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_err_timeout", 32'(bus.err_timeout_o), 0);
    bus.req_valid_i = '0;
    bus.req_instr_i = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single MAC with pe_done 3 cycles after the handshake.
    bus.pe_ready_i = 1'b1;
    done_delay = 3;
    d0 = n_done;
    src_q[0].push_back(32'h1000_0000);
    run_idle(60);
    chk("mac_done_count", n_done - d0, 1);
    chk("mac_issue_lat", last_pev_cyc - last_acc_cyc, 3);
    chk("mac_done_lat", last_hs_cyc + 5, last_done_cyc);

    // Fairness: both requesters continuously valid; rr points at 1 now.
    done_delay = 1;
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      src_q[0].push_back(32'h1000_0100 + 32'(i));
      src_q[1].push_back(32'h2000_0200 + 32'(i));
    end
    run_idle(300);
    chk("fair_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) chk("fair_gnt", grant_log[i], (i + 1) % 2);

    // Full FIFO: PE not ready, six commands from req0.
    bus.pe_ready_i = 1'b0;
    done_delay = 2;
    n0 = n_acc;
    for (int i = 0; i < 6; i++) src_q[0].push_back(32'h3000_0010 + 32'(i));
    repeat (15) step();
    chk("full_accepts", n_acc - n0, 5);
    chk("full_ready", 32'(bus.req_ready_o), 0);
    chk("full_pe_valid", 32'(bus.pe_valid_o), 1);
    bus.pe_ready_i = 1'b1;
    run_idle(300);
    chk("full_accepts_all", n_acc - n0, 6);

    // Illegal opcode: error completion, no PE issue.
    h0 = n_hs;
    src_q[1].push_back(32'h7000_0000);
    run_idle(50);
    chk("ill_no_issue", n_hs - h0, 0);
    chk("ill_done_lat", last_done_cyc - last_acc_cyc, 3);

    // Stray pe_done while idle must be ignored.
    d0 = n_done;
    step();
    pe_kick = 1'b1;
    step();
    pe_kick = 1'b0;
    repeat (4) step();
    chk("stray_done", n_done - d0, 0);

    // Timeout: PE never answers.
    done_delay = 0;
    src_q[0].push_back(32'h1000_0abc);
    run_idle(100);
    chk("tmo_lat", last_done_cyc - last_hs_cyc, TMO + 2);
    chk("tmo_sticky", 32'(bus.err_timeout_o), 1);
    done_delay = 2;
    src_q[1].push_back(32'h2000_0005);
    run_idle(60);
    chk("tmo_sticky_hold", 32'(bus.err_timeout_o), 1);

    // Reset while ACT is outstanding in WAIT.
    done_delay = 0;
    h0 = n_hs;
    src_q[0].push_back(32'h2000_0001);
    for (int i = 0; i < 30 && n_hs == h0; i++) step();
    chk("rst_hs_seen", 32'(n_hs > h0), 1);
    repeat (2) step();
    d0 = n_done;
    bus.req_valid_i[1] = 1'b1;
    bus.req_instr_i[63:32] = 32'h3000_0002;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pe_instr", bus.pe_instr_o, 0);
    chk("mid_rst_busy", 32'(bus.busy_o), 0);
    chk("mid_rst_err_timeout", 32'(bus.err_timeout_o), 0);
    chk("mid_rst_req_ready", 32'(bus.req_ready_o), 0);
    chk("mid_rst_done_valid", 32'(bus.done_valid_o), 0);
    @(posedge clk);
    #1;
    bus.req_valid_i = '0;
    bus.req_instr_i = '0;
    for (int k = 0; k < NR; k++) src_q[k].delete();
    @(negedge clk);
    rst_n = 1'b1;
    done_delay = 2;
    src_q[1].push_back(32'h3000_0002);
    run_idle(60);
    chk("post_rst_done_count", n_done - d0, 1);
    chk("post_rst_err_timeout", 32'(bus.err_timeout_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
